// File: rtl/div_ctrl.sv
// div_ctrl: execute-stage controller for the iterative 32-bit divider.
// Accepts DIV/DIVU from EX, drives the divider start/cancel handshake with
// latched operands, stalls the pipeline while the divide runs and writes
// {remainder, quotient} to HI/LO with a one-cycle strobe. A flush while
// running cancels the divider and lets it settle for two cycles.
// Optional feature: define DIV_CTRL_WDOG_EN to add a run-time watchdog that
// aborts a divide after WDOG_CYCLES cycles, writing HI = LO = 0 and flagging
// div_err.
module div_ctrl #(
    parameter int WDOG_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_req,
    input  logic        ex_div_signed,
    input  logic [31:0] ex_opa,
    input  logic [31:0] ex_opb,
    input  logic        flush,
    output logic        stall_req,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_err,
    output logic        div_start,
    output logic        div_cancel,
    output logic        div_sign,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    input  logic [63:0] div_result,
    input  logic        div_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state_r;
    logic   drain_cnt_r;   // second DRAIN cycle marker
    logic   accept_s;      // a new divide is taken this cycle
    logic   timeout_s;     // watchdog expires in this RUN cycle
    logic   wdog_hit_s;    // current DONE was produced by the watchdog

    // The watchdog counter is 6 bits wide, so the limit must fit in it.
    if (WDOG_CYCLES < 2 || WDOG_CYCLES > 63) begin : g_wdog_cfg_bad
        $error("div_ctrl: WDOG_CYCLES must lie in 2..63");
    end

    assign accept_s = (state_r == S_IDLE) && ex_div_req && !flush;

`ifdef DIV_CTRL_WDOG_EN
    // The counter is cleared on accept and lags cycles-since-accept by one,
    // so the abort decision is taken when it reads WDOG_CYCLES-2; DONE then
    // lands exactly WDOG_CYCLES cycles after the accept cycle.
    localparam logic [5:0] WDOG_LAST = 6'(WDOG_CYCLES - 2);

    logic [5:0] wdog_cnt_r;
    logic       wdog_hit_r;

    assign timeout_s  = (wdog_cnt_r == WDOG_LAST);
    assign wdog_hit_s = wdog_hit_r;

    // Watchdog: count RUN cycles and remember whether the abort path fired.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt_r <= 6'd0;
            wdog_hit_r <= 1'b0;
        end else if (accept_s) begin
            wdog_cnt_r <= 6'd0;
            wdog_hit_r <= 1'b0;
        end else if (state_r == S_RUN) begin
            wdog_cnt_r <= wdog_cnt_r + 6'd1;
            wdog_hit_r <= !flush && !div_done && timeout_s;
        end else if (state_r == S_DONE) begin
            wdog_hit_r <= 1'b0;
        end
    end
`else
    assign timeout_s  = 1'b0;
    assign wdog_hit_s = 1'b0;
`endif

    // Main sequencer: operand latch, result capture and state transitions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            drain_cnt_r <= 1'b0;
            div_sign    <= 1'b0;
            div_opa     <= 32'd0;
            div_opb     <= 32'd0;
            hi_o        <= 32'd0;
            lo_o        <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        div_sign <= ex_div_signed;
                        div_opa  <= ex_opa;
                        div_opb  <= ex_opb;
                        state_r  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Flush beats a coincident div_done: the result is dropped.
                    if (flush) begin
                        drain_cnt_r <= 1'b0;
                        state_r     <= S_DRAIN;
                    end else if (div_done) begin
                        hi_o    <= div_result[63:32];
                        lo_o    <= div_result[31:0];
                        state_r <= S_DONE;
                    end else if (timeout_s) begin
                        hi_o    <= 32'd0;
                        lo_o    <= 32'd0;
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (wdog_hit_s) begin
                        drain_cnt_r <= 1'b0;
                        state_r     <= S_DRAIN;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_r) begin
                        drain_cnt_r <= 1'b0;
                        state_r     <= S_IDLE;
                    end else begin
                        drain_cnt_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake and pipeline strobes; start and cancel are mutually exclusive.
    always_comb begin
        stall_req  = 1'b0;
        div_start  = 1'b0;
        div_cancel = 1'b0;
        hilo_we    = 1'b0;
        div_err    = 1'b0;
        case (state_r)
            S_IDLE: begin
                stall_req = accept_s;
                div_start = accept_s;
            end
            S_RUN: begin
                stall_req  = 1'b1;
                div_start  = !flush;
                div_cancel = flush;
            end
            S_DONE: begin
                hilo_we    = !flush;
                div_cancel = wdog_hit_s;
                div_err    = wdog_hit_s;
            end
            S_DRAIN: begin
                stall_req = 1'b0;
            end
            default: begin
                stall_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl. The bench plays the divider
// (35-cycle latency, 3 cycles for a zero divisor) and checks the controller
// against cycle expectations derived from the divide timing rules.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_div_req = 1'b0;
    logic        ex_div_signed = 1'b0;
    logic [31:0] ex_opa = 32'd0;
    logic [31:0] ex_opb = 32'd0;
    logic        flush = 1'b0;
    logic        stall_req, hilo_we, div_err, div_start, div_cancel, div_sign;
    logic [31:0] hi_o, lo_o, div_opa, div_opb;
    logic [63:0] div_result = 64'd0;
    logic        div_done = 1'b0;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk(clk), .rst(rst), .ex_div_req(ex_div_req), .ex_div_signed(ex_div_signed),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .flush(flush), .stall_req(stall_req),
        .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o), .div_err(div_err),
        .div_start(div_start), .div_cancel(div_cancel), .div_sign(div_sign),
        .div_opa(div_opa), .div_opb(div_opb), .div_result(div_result), .div_done(div_done)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          dcnt = 0;          // cycles the divider has seen start held
    logic        hang = 1'b0;       // divider never completes
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          flush_at;      // 0 = none, else cycle index from accept
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[10];

    // {remainder, quotient}; signed divide truncates toward zero, x/0 gives 0.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Let combinational outputs settle, then drive the divider's response.
    task automatic settle();
        #1;
        div_done   = div_start && !hang && (dcnt == ((div_opb == 32'd0) ? 3 : 35));
        div_result = div_done ? ref_div(div_sign, div_opa, div_opb) : {$urandom, $urandom};
        #1;
    endtask

    task automatic advance();
        logic start_smp;
        start_smp = div_start;
        @(posedge clk);
        dcnt = start_smp ? dcnt + 1 : 0;
        @(negedge clk);
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int flush_at, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   lat, end_k;
        logic flushed, e_stall, e_start, e_cancel, e_we;
        lat     = (b == 32'd0) ? 3 : 35;
        flushed = (flush_at >= 1) && (flush_at <= lat);
        end_k   = flushed ? flush_at + 2 : lat + 1;
        for (int k = 0; k <= end_k; k++) begin
            ex_div_req = 1'b1;   // held through DONE/DRAIN, which must ignore it
            flush      = (flush_at > 0) && (k == flush_at);
            if (k == 0) begin
                {ex_div_signed, ex_opa, ex_opb} = {sgn, a, b};
            end else begin
                ex_div_signed = 1'($urandom);
                ex_opa        = $urandom;
                ex_opb        = $urandom;
            end
            settle();
            if (flushed) begin
                e_stall  = (k <= flush_at);
                e_start  = (k < flush_at);
                e_cancel = (k == flush_at);
                e_we     = 1'b0;
            end else begin
                e_stall  = (k <= lat);
                e_start  = (k <= lat);
                e_cancel = 1'b0;
                e_we     = (k == lat + 1) && (flush_at != lat + 1);
            end
            check($sformatf("stall_req k=%0d", k), stall_req, e_stall);
            check($sformatf("div_start k=%0d", k), div_start, e_start);
            check($sformatf("div_cancel k=%0d", k), div_cancel, e_cancel);
            check($sformatf("hilo_we k=%0d", k), hilo_we, e_we);
            check($sformatf("div_err k=%0d", k), div_err, 1'b0);
            if (k >= 1 && e_stall)
                check($sformatf("operands k=%0d", k), {31'd0, div_sign, div_opa, div_opb}, {31'd0, sgn, a, b});
            if (!flushed && k == lat + 1)
                check($sformatf("hi/lo %0h/%0h", a, b), {hi_o, lo_o}, {exp_hi, exp_lo});
            advance();
        end
        if (!flushed) begin
            last_hi = exp_hi;
            last_lo = exp_lo;
        end
        ex_div_req = 1'b0;
        flush      = 1'b0;
    endtask

    // Idle cycles with a stray div_done that must not disturb HI/LO.
    task automatic idle_gap(input int n);
        for (int i = 0; i <= n; i++) begin
            ex_div_req = 1'b0;
            flush      = 1'b0;
            settle();
            check("idle stall_req", stall_req, 1'b0);
            check("idle hilo_we", hilo_we, 1'b0);
            check("idle hi/lo hold", {hi_o, lo_o}, {last_hi, last_lo});
            if (i < n) begin
                div_done   = 1'b1;
                div_result = {$urandom, $urandom};
            end
            advance();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 32'd100,        32'd7,          0,  32'd2,          32'd14};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          0,  32'hFFFF_FFFF,  32'hFFFF_FFFD};
        tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  0,  32'd1,          32'hFFFF_FFFD};
        tbl[3] = '{1'b0, 32'd5,          32'd0,          0,  32'd0,          32'd0};
        tbl[4] = '{1'b0, 32'd100,        32'd7,          10, 32'd0,          32'd0};
        tbl[5] = '{1'b0, 32'd9,          32'd3,          0,  32'd0,          32'd3};
        tbl[6] = '{1'b0, 32'd8,          32'd2,          0,  32'd0,          32'd4};
        tbl[7] = '{1'b0, 32'd9,          32'd4,          0,  32'd1,          32'd2};
        tbl[8] = '{1'b0, 32'd100,        32'd7,          36, 32'd2,          32'd14};
        tbl[9] = '{1'b0, 32'hFFFF_FFFF,  32'h10,         0,  32'hF,          32'h0FFF_FFFF};

        // Reset state
        #2;
        check("reset stall/we/err", {stall_req, hilo_we, div_err}, 3'b000);
        check("reset start/cancel/sign", {div_start, div_cancel, div_sign}, 3'b000);
        check("reset hi/lo", {hi_o, lo_o}, 64'd0);
        check("reset operands", {div_opa, div_opb}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Flush in IDLE suppresses accept; the real divide follows next cycle.
        ex_div_req = 1'b1;
        flush      = 1'b1;
        ex_opa     = 32'd55;
        ex_opb     = 32'd0;
        settle();
        check("flush idle stall_req", stall_req, 1'b0);
        check("flush idle div_start", div_start, 1'b0);
        advance();

        // Directed table: back-to-back, flush in RUN and in DONE included.
        for (int i = 0; i < 10; i++)
            run_div(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].flush_at, tbl[i].hi, tbl[i].lo);
        idle_gap(2);

        // Asynchronous reset in the middle of RUN.
        ex_div_req    = 1'b1;
        ex_div_signed = 1'b1;
        ex_opa        = 32'd1000;
        ex_opb        = 32'd3;
        for (int k = 0; k < 6; k++) begin
            settle();
            advance();
        end
        ex_div_req = 1'b0;
        settle();
        rst = 1'b0;
        #1;
        check("async reset stall/we/err", {stall_req, hilo_we, div_err}, 3'b000);
        check("async reset start/cancel", {div_start, div_cancel}, 2'b00);
        check("async reset hi/lo", {hi_o, lo_o}, 64'd0);
        check("async reset operands", {31'd0, div_sign, div_opa, div_opb}, 96'd0);
        advance();
        advance();
        rst     = 1'b1;
        last_hi = 32'd0;
        last_lo = 32'd0;
        idle_gap(1);

        // Randomized divides checked against the reference arithmetic.
        for (int n = 0; n < 30; n++) begin
            logic        sgn;
            logic [31:0] a, b;
            logic [63:0] r;
            int          lat, fa;
            sgn = 1'($urandom);
            a   = $urandom;
            b   = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            lat = (b == 32'd0) ? 3 : 35;
            fa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat + 1)) : 0;
            r   = ref_div(sgn, a, b);
            run_div(sgn, a, b, fa, r[63:32], r[31:0]);
            if ($urandom_range(0, 1) == 1) idle_gap(int'($urandom_range(1, 3)));
        end

`ifdef DIV_CTRL_WDOG_EN
        // Watchdog abort with the default limit of 48 cycles.
        hang = 1'b1;
        for (int k = 0; k <= 51; k++) begin
            ex_div_req = (k <= 50);
            if (k == 0) {ex_div_signed, ex_opa, ex_opb} = {1'b0, 32'd100, 32'd7};
            settle();
            check($sformatf("wdog stall_req k=%0d", k), stall_req, (k <= 47));
            check($sformatf("wdog div_start k=%0d", k), div_start, (k <= 47));
            check($sformatf("wdog hilo_we k=%0d", k), hilo_we, (k == 48));
            check($sformatf("wdog div_err k=%0d", k), div_err, (k == 48));
            check($sformatf("wdog div_cancel k=%0d", k), div_cancel, (k == 48));
            if (k == 48) check("wdog hi/lo", {hi_o, lo_o}, 64'd0);
            advance();
        end
        hang       = 1'b0;
        ex_div_req = 1'b0;
        last_hi    = 32'd0;
        last_lo    = 32'd0;
`endif

        run_div(1'b0, 32'd9, 32'd3, 0, 32'd0, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
